// File: rtl/mem_ctrl_pkg.sv
// Shared widths, state codes and size codes for the memory controller.
package mem_ctrl_pkg;
  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int DATA_W = 32;
  localparam int RAM_W  = 8;

  localparam logic TRUE       = 1'b1;
  localparam logic FALSE      = 1'b0;
  localparam logic RST_ENABLE = 1'b0;

  typedef enum logic [1:0] {
    MC_IDLE   = 2'd0,
    MC_IFETCH = 2'd1,
    MC_DREAD  = 2'd2,
    MC_DWRITE = 2'd3
  } mc_state_e;

  localparam logic [2:0] SIZE_B = 3'd1;
  localparam logic [2:0] SIZE_H = 3'd2;
  localparam logic [2:0] SIZE_W = 3'd4;

  // Anything other than a byte or half access is treated as a word so the
  // byte counter always has a reachable end.
  function automatic logic [2:0] norm_size(input logic [2:0] s);
    case (s)
      SIZE_B:  return SIZE_B;
      SIZE_H:  return SIZE_H;
      default: return SIZE_W;
    endcase
  endfunction
endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates icache fetches and load/store
// accesses onto the byte-wide RAM port, one access in flight at a time.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [RAM_W-1:0]  mem_din,
  output logic [RAM_W-1:0]  mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              inst_require_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic              flush_i,
  output logic              inst_busy_o,
  output logic              inst_enable_o,
  output logic [INST_W-1:0] inst_data_o,
  input  logic              data_require_i,
  input  logic              data_we_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [2:0]        data_size_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic              data_busy_o,
  output logic              data_enable_o,
  output logic [DATA_W-1:0] data_rdata_o
);
  mc_state_e         state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        n, k, prev_idx;
  logic [DATA_W-1:0] wdata, asm_q, cap_word;
  logic              prev_vld, last_got;
  logic              is_rd, issue, cap, last_now, rd_fin;
  logic              accept, fin, flush_go;

  assign is_rd    = (state == MC_IFETCH) || (state == MC_DREAD);
  assign issue    = is_rd && (k < n);
  assign cap      = is_rd && prev_vld;
  assign last_now = cap && (prev_idx == n - 3'd1);
  // last_got covers a final byte that landed while rdy was low
  assign rd_fin   = is_rd && (last_now || last_got);

  assign inst_busy_o = (state != MC_IDLE);
  assign data_busy_o = (state != MC_IDLE);

  always_comb begin
    cap_word = asm_q;
    for (int i = 0; i < 4; i++)
      if (cap && (prev_idx == 3'(i))) cap_word[8*i +: 8] = mem_din;
  end

  always_comb begin
    state_n  = state;
    accept   = FALSE;
    fin      = FALSE;
    flush_go = FALSE;
    mem_a    = '0;
    mem_wr   = FALSE;
    mem_dout = '0;
    case (state)
      MC_IDLE: begin
        if (data_require_i) begin
          accept  = TRUE;
          state_n = data_we_i ? MC_DWRITE : MC_DREAD;
        end else if (inst_require_i && !flush_i) begin
          accept  = TRUE;
          state_n = MC_IFETCH;
        end
      end
      MC_IFETCH, MC_DREAD: begin
        if (issue) mem_a = addr + {29'd0, k};
        if ((state == MC_IFETCH) && flush_i) begin
          flush_go = TRUE;
          state_n  = MC_IDLE;
        end else if (rd_fin) begin
          fin     = TRUE;
          state_n = MC_IDLE;
        end
      end
      MC_DWRITE: begin
        mem_a    = addr + {29'd0, k};
        mem_dout = 8'(wdata >> {k, 3'b000});
        mem_wr   = rdy;
        if (k == n - 3'd1) begin
          fin     = TRUE;
          state_n = MC_IDLE;
        end
      end
      default: state_n = MC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) state <= MC_IDLE;
    else if (rdy)          state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      addr          <= '0;
      n             <= '0;
      k             <= '0;
      wdata         <= '0;
      asm_q         <= '0;
      prev_vld      <= FALSE;
      prev_idx      <= '0;
      last_got      <= FALSE;
      inst_enable_o <= FALSE;
      data_enable_o <= FALSE;
      inst_data_o   <= '0;
      data_rdata_o  <= '0;
    end else begin
      prev_vld      <= issue && rdy;
      prev_idx      <= k;
      inst_enable_o <= FALSE;
      data_enable_o <= FALSE;
      // The byte on mem_din exists only this cycle, so it lands even when stalled.
      if (cap)      asm_q    <= cap_word;
      if (last_now) last_got <= TRUE;
      if (rdy) begin
        if (accept) begin
          addr     <= data_require_i ? data_addr_i : inst_addr_i;
          n        <= data_require_i ? norm_size(data_size_i) : SIZE_W;
          wdata    <= data_wdata_i;
          k        <= '0;
          asm_q    <= '0;
          last_got <= FALSE;
        end else if (flush_go) begin
          k        <= '0;
          last_got <= FALSE;
        end else if (fin) begin
          k <= '0;
          if (state == MC_IFETCH) begin
            inst_enable_o <= TRUE;
            inst_data_o   <= cap_word;
          end else begin
            data_enable_o <= TRUE;
            data_rdata_o  <= (state == MC_DREAD) ? cap_word : '0;
          end
        end else if (issue || (state == MC_DWRITE)) begin
          k <= k + 3'd1;
        end
      end
    end
  end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the byte-wide external RAM port and the CPU's two memory clients: the instruction cache (word fetches) and the load/store path (1/2/4-byte loads and stores). It serialises each request into byte accesses, assembles or scatters little-endian words, and arbitrates the two clients so only one access is in flight. It sits directly upstream of the icache, which drives require/address and consumes busy/enable/data.

## Interface
- No parameters; widths come from the shared defines (32-bit address and data, 8-bit RAM data).
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous and active-low: rst==0 at a rising edge resets the block.
- rdy  in  1  global enable; low freezes all state.
- mem_din  in  8  RAM read byte for the address driven in the previous cycle.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  1 = write this cycle.
- inst_require_i  in  1  icache fetch request.
- inst_addr_i  in  32  fetch address, word aligned.
- flush_i  in  1  cancel any in-flight instruction fetch (mispredict).
- inst_busy_o  out  1  controller not idle.
- inst_enable_o  out  1  one-cycle pulse: fetched word valid.
- inst_data_o  out  32  fetched word.
- data_require_i  in  1  load/store request.
- data_we_i  in  1  1 = store.
- data_addr_i  in  32  byte address.
- data_size_i  in  3  byte count: 1, 2 or 4.
- data_wdata_i  in  32  store data, low bytes used.
- data_busy_o  out  1  controller not idle.
- data_enable_o  out  1  one-cycle pulse: load data valid or store complete.
- data_rdata_o  out  32  load data, zero-extended; the load unit sign-extends.

## Operation
- States: IDLE, IFETCH, DREAD, DWRITE. The encoding lives in the shared defines.
- IDLE acceptance:
  - data_require_i wins over inst_require_i; stores are committed work.
  - A request is latched on the edge where it is seen with rdy=1. The latch covers address, size (4 for fetch), write data and byte counter=0.
  - A data request goes to DREAD or DWRITE per data_we_i. A fetch goes to IFETCH unless flush_i is high that cycle.
- Busy outputs: inst_busy_o = data_busy_o = (state != IDLE), driven from the state register.
- Read states (IFETCH, DREAD):
  - Issue pass: counter k=0..N-1 drives mem_a=addr+k, mem_wr=0.
  - Capture: the byte on mem_din at edge t is the byte for the address driven in cycle t-1. It is stored at bit position 8·k_prev, little-endian.
  - A prev-issue-index register updates every clock, even with rdy low, so a stall never misaligns captures.
  - After the last byte (index N-1) is captured: return to IDLE and pulse the matching enable with the assembled word. Unused upper bytes are 0.
- DWRITE:
  - Cycle k drives mem_wr=1, mem_a=addr+k, mem_dout=wdata[8k+7:8k].
  - After byte N-1: return to IDLE and pulse data_enable_o. data_rdata_o = 0.
- Outputs outside active issue: mem_wr=0, mem_a=0, mem_dout=0.
- rdy low:
  - Registers hold, except the prev-issue index.
  - mem_wr is forced 0 combinationally, so no duplicate or IO writes.
- flush_i:
  - In IFETCH: on the next edge, state→IDLE, counter cleared, no inst_enable_o pulse. This also applies if the flush coincides with the final capture edge.
  - No effect on DREAD or DWRITE.
- Reset (including mid-access): state=IDLE, counter=0. All outputs 0: mem_wr, mem_a, mem_dout, both enables, both data outputs; busy outputs 0.

## Timing
- Request accepted at the edge ending cycle T.
- Read of N bytes: addresses issued in cycles T+1..T+N; bytes captured at edges ending T+2..T+N+1; enable high in cycle T+N+2, data valid with it.
- Fetch latency: enable in cycle T+6.
- Write of N bytes: mem_wr high in cycles T+1..T+N; data_enable_o high in cycle T+N+1.
- The enable cycle is already IDLE with busy=0, so a new request seen in that cycle is accepted (back-to-back).
- Enable pulses last exactly one cycle. Data outputs hold their value until the next completion.
- Each rdy-low cycle adds exactly one cycle of latency.

## Structure
- Shared defines file holds:
  - address, instruction and data bus ranges;
  - True/False;
  - RstEnable, now 1'b0;
  - state codes MC_IDLE/MC_IFETCH/MC_DREAD/MC_DWRITE;
  - size codes.
- Single module, no sub-module: the byte shifter and the FSM are too small to split.

## Test plan
- Fetch at 0x0000_1000 with RAM bytes 13 05 00 00 → inst_enable_o in T+6 with inst_data_o=0x0000_0513; mem_a 0x1000..0x1003 in T+1..T+4.
- Simultaneous inst and data requests; load size 2 at 0x20 holding 0xBEEF → load served first, data_rdata_o=0x0000_BEEF; fetch accepted in the enable cycle, back-to-back.
- Store size 4 of 0xDEADBEEF at 0x100 → mem_wr high 4 cycles with bytes EF BE AD DE at 0x100..0x103; data_enable_o in T+5.
- flush_i in T+3 of a fetch → IDLE at the next edge, no inst_enable_o; a new fetch is then served normally.
- rdy low for 2 cycles mid-fetch and mid-store → correct word, latency +2, no mem_wr while rdy=0.
- rst=0 during DWRITE → next cycle mem_wr=0, busy=0, state IDLE; a subsequent load returns correct data.
